// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the host bus in clk7, deserialises received bytes,
// serialises bytes from a one-deep transmit buffer and keeps a bitwise CRC16-CCITT.
//
// Ports:
//   clk7, _reset             system clock, async active-low reset
//   _cs_in, sclk_in, mosi_in host-driven SPI bus (asynchronous to clk7)
//   miso_out, miso_oe        target data out and its driver enable
//   selected                 synchronised, inverted chip select
//   rx_data, rx_valid        last complete received byte and its update pulse
//   tx_data, tx_load         byte to transmit and its write strobe
//   tx_ready, tx_underrun    buffer empty flag, idle-byte substitution pulse
//   crc_source, crc_reset    CRC bit select (0 mosi, 1 miso) and sync clear
//   crc_out                  running CRC16, poly 0x1021, init 0x0000

module spi_target #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic        clk7,
   input  logic        _reset,
   input  logic        _cs_in,
   input  logic        sclk_in,
   input  logic        mosi_in,
   output logic        miso_out,
   output logic        miso_oe,
   output logic        selected,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic [7:0]  tx_data,
   input  logic        tx_load,
   output logic        tx_ready,
   output logic        tx_underrun,
   input  logic        crc_source,
   input  logic        crc_reset,
   output logic [15:0] crc_out
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_cs_hist;
   logic                   r_sclk_hist;

   logic [6:0]  r_rx_shift;
   logic [2:0]  r_bit_cnt;
   logic        r_byte_done;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;

   logic [7:0]  r_tx_shift;
   logic [7:0]  r_tx_buf;
   logic        r_tx_ready;
   logic        r_tx_underrun;

   logic [15:0] r_crc;

   logic w_cs, w_sclk, w_mosi;
   logic w_cs_fall, w_cs_rise;
   logic w_sclk_rise, w_sclk_fall;
   logic w_start, w_leave;
   logic w_rise, w_fall;
   logic w_reload, w_accept;
   logic w_crc_bit, w_crc_fb;

   assign w_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   assign w_cs_fall   = r_cs_hist & ~w_cs;
   assign w_cs_rise   = ~r_cs_hist & w_cs;
   assign w_sclk_rise = ~r_sclk_hist & w_sclk;
   assign w_sclk_fall = r_sclk_hist & ~w_sclk;

   // Bus edges only count while selected and not being deselected.
   assign w_rise = (r_state == S_ACTIVE) & w_sclk_rise & ~w_cs_rise;
   assign w_fall = (r_state == S_ACTIVE) & w_sclk_fall & ~w_cs_rise;

   // Shifter reload: at selection and at the fall closing each byte.
   assign w_reload = w_start | (w_fall & r_byte_done);
   // A load coinciding with a reload lands behind the byte being moved out.
   assign w_accept = tx_load & (r_tx_ready | w_reload);

   assign w_crc_bit = crc_source ? r_tx_shift[7] : w_mosi;
   assign w_crc_fb  = r_crc[15] ^ w_crc_bit;

   always_ff @(posedge clk7 or negedge _reset) begin
      if (!_reset) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_hist   <= 1'b1;
         r_sclk_hist <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], _cs_in};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
         r_cs_hist   <= w_cs;
         r_sclk_hist <= w_sclk;
      end
   end

   always_ff @(posedge clk7 or negedge _reset) begin
      if (!_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_leave     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = S_ACTIVE;
               w_start     = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (w_cs_rise) begin
               w_state_nxt = S_IDLE;
               w_leave     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk7 or negedge _reset) begin
      if (!_reset) begin
         r_rx_shift  <= '0;
         r_bit_cnt   <= '0;
         r_byte_done <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (w_leave) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
         end else if (w_rise) begin
            r_rx_shift <= {r_rx_shift[5:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_rx_data   <= {r_rx_shift, w_mosi};
               r_rx_valid  <= 1'b1;
               r_byte_done <= 1'b1;
            end
         end else if (w_fall && r_byte_done) begin
            r_byte_done <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk7 or negedge _reset) begin
      if (!_reset) begin
         r_tx_shift    <= 8'hFF;
         r_tx_buf      <= '0;
         r_tx_ready    <= 1'b1;
         r_tx_underrun <= 1'b0;
      end else begin
         r_tx_underrun <= w_reload & r_tx_ready;
         if (w_leave)
            r_tx_shift <= 8'hFF;
         else if (w_reload)
            r_tx_shift <= r_tx_ready ? IDLE_BYTE : r_tx_buf;
         else if (w_fall)
            r_tx_shift <= {r_tx_shift[6:0], 1'b1};
         if (w_accept) begin
            r_tx_buf   <= tx_data;
            r_tx_ready <= 1'b0;
         end else if (w_reload) begin
            r_tx_ready <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk7 or negedge _reset) begin
      if (!_reset)
         r_crc <= '0;
      else if (crc_reset)
         r_crc <= '0;
      else if (w_rise)
         r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
   end

   assign selected    = (r_state == S_ACTIVE);
   assign miso_oe     = (r_state == S_ACTIVE);
   assign miso_out    = r_tx_shift[7];
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_ready    = r_tx_ready;
   assign tx_underrun = r_tx_underrun;
   assign crc_out     = r_crc;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a mode-0 host model with received-byte
// and host-sampled-byte scoreboards.

module tb_spi_target;

   localparam int HALF = 4;

   logic        clk7 = 1'b0;
   logic        _reset;
   logic        _cs_in;
   logic        sclk_in;
   logic        mosi_in;
   logic        miso_out;
   logic        miso_oe;
   logic        selected;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_load;
   logic        tx_ready;
   logic        tx_underrun;
   logic        crc_source;
   logic        crc_reset;
   logic [15:0] crc_out;

   int n_cmp = 0;
   int n_err = 0;
   int n_rxv = 0;
   int n_unr = 0;

   logic [7:0] q_rx[$];
   logic [7:0] q_miso[$];

   always #5 clk7 = ~clk7;

   spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk7(clk7), ._reset(_reset), ._cs_in(_cs_in), .sclk_in(sclk_in),
      .mosi_in(mosi_in), .miso_out(miso_out), .miso_oe(miso_oe),
      .selected(selected), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .crc_source(crc_source),
      .crc_reset(crc_reset), .crc_out(crc_out)
   );

   always @(negedge clk7) begin
      logic [7:0] exp;
      if (rx_valid === 1'b1) begin
         n_rxv++;
         n_cmp++;
         if (q_rx.size() == 0) begin
            n_err++;
            $display("FAIL rx_unexpected: rx_data=%h, nothing expected", rx_data);
         end else begin
            exp = q_rx.pop_front();
            if (rx_data !== exp) begin
               n_err++;
               $display("FAIL rx_data: got %h want %h", rx_data, exp);
            end
         end
      end
      if (tx_underrun === 1'b1) n_unr++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] crc_byte(logic [15:0] c, logic [7:0] b);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ b[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk7);
   endtask

   task automatic load_tx(input logic [7:0] b);
      tx_data = b;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
      tick(1);
   endtask

   task automatic pulse_crc_reset();
      crc_reset = 1'b1;
      tick(1);
      crc_reset = 1'b0;
      tick(1);
   endtask

   task automatic cs_begin();
      _cs_in = 1'b0;
      tick(HALF + 2);
   endtask

   task automatic cs_end();
      tick(HALF);
      _cs_in = 1'b1;
      tick(HALF + 2);
   endtask

   task automatic spi_bit(input logic mo, output logic mi);
      mosi_in = mo;
      tick(HALF);
      mi = miso_out;
      sclk_in = 1'b1;
      tick(HALF);
      sclk_in = 1'b0;
   endtask

   task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi);
      logic b;
      logic [7:0] exp;
      q_rx.push_back(mo);
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mo[i], b);
         mi[i] = b;
      end
      n_cmp++;
      if (q_miso.size() == 0) begin
         n_err++;
         $display("FAIL miso_unexpected: host read %h, nothing expected", mi);
      end else begin
         exp = q_miso.pop_front();
         if (mi !== exp) begin
            n_err++;
            $display("FAIL miso_byte: host read %h want %h", mi, exp);
         end
      end
   endtask

   task automatic test_reset();
      _reset = 1'b0;
      _cs_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
      tx_data = '0; tx_load = 1'b0;
      crc_source = 1'b0; crc_reset = 1'b0;
      tick(3);
      _reset = 1'b1;
      tick(3);
      n_cmp++;
      if ({miso_out, miso_oe, selected, rx_valid, tx_ready, tx_underrun} !== 6'b100010) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 100010",
                  {miso_out, miso_oe, selected, rx_valid, tx_ready, tx_underrun});
      end
      n_cmp++;
      if (rx_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset_rx_data: got %h want 00", rx_data);
      end
      n_cmp++;
      if (crc_out !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_crc: got %h want 0000", crc_out);
      end
   endtask

   task automatic test_basic();
      logic [7:0] mi;
      int v0;
      load_tx(8'h3C);
      n_cmp++;
      if (tx_ready !== 1'b0) begin
         n_err++;
         $display("FAIL basic_ready_after_load: got %b want 0", tx_ready);
      end
      v0 = n_rxv;
      q_miso.push_back(8'h3C);
      cs_begin();
      n_cmp++;
      if ({tx_ready, selected, miso_oe} !== 3'b111) begin
         n_err++;
         $display("FAIL basic_select: ready/sel/oe got %b want 111",
                  {tx_ready, selected, miso_oe});
      end
      spi_xfer(8'hA5, mi);
      cs_end();
      n_cmp++;
      if (n_rxv - v0 != 1) begin
         n_err++;
         $display("FAIL basic_rx_pulses: got %0d want 1", n_rxv - v0);
      end
      n_cmp++;
      if (rx_data !== 8'hA5) begin
         n_err++;
         $display("FAIL basic_rx_hold: got %h want a5", rx_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi;
      int u0;
      load_tx(8'h12);
      q_miso.push_back(8'h12);
      cs_begin();
      u0 = n_unr;
      spi_xfer(8'h5A, mi);
      tick(HALF);
      n_cmp++;
      if (n_unr - u0 != 1) begin
         n_err++;
         $display("FAIL b2b_underrun_first: got %0d want 1", n_unr - u0);
      end
      q_miso.push_back(8'hFF);
      spi_xfer(8'hC3, mi);
      cs_end();
      n_cmp++;
      if (n_unr - u0 != 2) begin
         n_err++;
         $display("FAIL b2b_underrun_total: got %0d want 2", n_unr - u0);
      end
   endtask

   task automatic test_crc_mosi();
      logic [7:0]  mi;
      logic [15:0] exp;
      crc_source = 1'b0;
      pulse_crc_reset();
      n_cmp++;
      if (crc_out !== 16'h0000) begin
         n_err++;
         $display("FAIL crc_clear: got %h want 0000", crc_out);
      end
      cs_begin();
      for (int i = 1; i <= 9; i++) begin
         q_miso.push_back(8'hFF);
         spi_xfer(8'h30 + 8'(i), mi);
      end
      cs_end();
      n_cmp++;
      if (crc_out !== 16'h31C3) begin
         n_err++;
         $display("FAIL crc_mosi_check: got %h want 31c3", crc_out);
      end
      pulse_crc_reset();
      exp = 16'h0000;
      cs_begin();
      for (int i = 0; i < 512; i++) begin
         q_miso.push_back(8'hFF);
         spi_xfer(8'hFF, mi);
         exp = crc_byte(exp, 8'hFF);
      end
      cs_end();
      n_cmp++;
      if (crc_out !== exp) begin
         n_err++;
         $display("FAIL crc_ff512: got %h want %h", crc_out, exp);
      end
   endtask

   task automatic test_crc_miso();
      logic [7:0] mi;
      crc_source = 1'b1;
      pulse_crc_reset();
      for (int i = 1; i <= 9; i++) begin
         load_tx(8'h30 + 8'(i));
         q_miso.push_back(8'h30 + 8'(i));
         cs_begin();
         spi_xfer(8'h00, mi);
         cs_end();
      end
      n_cmp++;
      if (crc_out !== 16'h31C3) begin
         n_err++;
         $display("FAIL crc_miso_check: got %h want 31c3", crc_out);
      end
      crc_source = 1'b0;
   endtask

   task automatic test_partial();
      logic [7:0] mi;
      logic       b;
      logic [7:0] pat;
      int v0;
      v0  = n_rxv;
      pat = 8'hF0;
      cs_begin();
      for (int i = 7; i >= 3; i--) spi_bit(pat[i], b);
      cs_end();
      n_cmp++;
      if ({miso_oe, selected} !== 2'b00) begin
         n_err++;
         $display("FAIL partial_deselect: oe/sel got %b want 00", {miso_oe, selected});
      end
      n_cmp++;
      if (n_rxv != v0) begin
         n_err++;
         $display("FAIL partial_rx_pulses: got %0d want 0", n_rxv - v0);
      end
      q_miso.push_back(8'hFF);
      cs_begin();
      spi_xfer(8'h81, mi);
      cs_end();
      n_cmp++;
      if (rx_data !== 8'h81) begin
         n_err++;
         $display("FAIL partial_next_byte: got %h want 81", rx_data);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi;
      logic       b;
      cs_begin();
      load_tx(8'h77);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
      mosi_in = 1'b1;
      tick(2);
      sclk_in = 1'b1;
      tick(3);
      _reset = 1'b0;
      #1;
      n_cmp++;
      if ({miso_out, miso_oe, selected, rx_valid, tx_ready, tx_underrun} !== 6'b100010) begin
         n_err++;
         $display("FAIL midreset_flags: got %b want 100010",
                  {miso_out, miso_oe, selected, rx_valid, tx_ready, tx_underrun});
      end
      n_cmp++;
      if ({rx_data, crc_out} !== 24'h000000) begin
         n_err++;
         $display("FAIL midreset_data: rx=%h crc=%h want 00/0000", rx_data, crc_out);
      end
      sclk_in = 1'b0;
      _cs_in  = 1'b1;
      mosi_in = 1'b0;
      tick(2);
      _reset = 1'b1;
      tick(4);
      q_miso.push_back(8'hFF);
      cs_begin();
      spi_xfer(8'h55, mi);
      cs_end();
      n_cmp++;
      if (rx_data !== 8'h55) begin
         n_err++;
         $display("FAIL midreset_recover: got %h want 55", rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_crc_mosi();
      test_crc_miso();
      test_partial();
      test_reset_mid();
      tick(4);
      n_cmp++;
      if (q_rx.size() != 0 || q_miso.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: rx left %0d, miso left %0d want 0/0",
                  q_rx.size(), q_miso.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (peripheral side) for the same four-wire bus the Amiga-side SPI host drives.
- Oversamples _cs, sclk and mosi in the clk7 domain, deserialises received bytes and serialises transmit bytes from a one-deep buffer.
- Keeps a bitwise CRC16-CCITT over either direction.
- Used as an on-board loopback/diagnostic target and as the bus-functional responder in host-controller benches.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per input before edge detection (minimum 2).
- IDLE_BYTE, 8'hFF: byte shifted out when the transmit buffer is empty.

Ports:
- clk7  input  1  7 MHz system clock
- _reset  input  1  asynchronous active-low reset
- _cs_in  input  1  SPI chip select from host, active low
- sclk_in  input  1  SPI clock from host, idle low
- mosi_in  input  1  SPI data host->target
- miso_out  output  1  SPI data target->host
- miso_oe  output  1  MISO driver enable, 1 while selected
- selected  output  1  synchronised, inverted _cs_in
- rx_data  output  8  last complete received byte
- rx_valid  output  1  one-cycle pulse when rx_data updates
- tx_data  input  8  next byte to transmit
- tx_load  input  1  write tx_data into the transmit buffer
- tx_ready  output  1  transmit buffer empty
- tx_underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted
- crc_source  input  1  0 = CRC over mosi bits, 1 = CRC over miso bits
- crc_reset  input  1  synchronous clear of the CRC
- crc_out  output  16  running CRC16 (poly 0x1021, init 0x0000)

Behaviour:
- Reset is applied asynchronously by _reset and released synchronously to clk7. Reset values:
  - miso_out=1, miso_oe=0, selected=0
  - rx_data=0, rx_valid=0
  - tx_ready=1, tx_underrun=0
  - crc_out=0
  - bit counter=0, transmit buffer empty.
- Input handling: each input passes through SYNC_STAGES flops plus one history flop. An sclk rise or fall is registered when the history flop and the last synchroniser stage differ.
- Host timing: sclk high and low phases are each at least 2 clk7 periods. _cs fall to first sclk rise is at least SYNC_STAGES+2 clk7 periods.
- States:
  - IDLE (selected=0):
    - miso_oe=0, bit counter held at 0, edges ignored.
    - Synced _cs falling -> ACTIVE.
    - On the transition, the transmit shifter loads the buffer (tx_ready->1) or IDLE_BYTE (tx_underrun pulse).
  - ACTIVE (selected=1):
    - miso_oe=1; miso_out = shifter bit 7.
    - sclk rise: shift the synced mosi into the receive shifter LSB-first-in (MSB received first). Increment the bit counter modulo 8.
    - On the 8th rise: rx_data <= assembled byte, rx_valid pulses 1 cycle, byte_done flag set.
    - sclk fall with byte_done=1: reload the transmit shifter from the buffer or IDLE_BYTE, as above; clear byte_done.
    - sclk fall with byte_done=0: shift the transmit shifter left one bit.
    - Synced _cs rising -> IDLE: partial receive byte discarded (no rx_valid), bit counter cleared, byte_done cleared, transmit shifter contents lost. Transmit buffer and tx_ready are retained.
- tx_load:
  - Accepted only when tx_ready=1: buffer <= tx_data, tx_ready->0 next cycle.
  - Ignored when tx_ready=0.
  - tx_load in the same cycle as a buffer reload: the reload takes the old buffer, the new byte is accepted, tx_ready ends 0.
- CRC:
  - Updated on every ACTIVE sclk rise with the bit selected by crc_source: fb = crc[15]^bit; crc = {crc[14:0],0} ^ (fb ? 0x1021 : 0).
  - crc_reset has priority over a same-cycle update.
  - crc_source changes take effect at the next rise.
  - CRC is unaffected by _cs transitions.
- All outputs are registered. Latency from a synced sclk rise to rx_valid is 1 clk7.

Test Plan:
- tx_load 0x3C before _cs falls; host sends 0xA5 -> host samples 0x3C, rx_data=0xA5 with a single rx_valid pulse, tx_ready=1 after _cs fall.
- Two-byte transfer with no second tx_load -> second host byte reads 0xFF, one tx_underrun pulse at the first-byte boundary fall.
- crc_reset, crc_source=0, host sends ASCII "123456789" -> crc_out=0x31C3. Repeat with 512 bytes of 0xFF -> 0x7FA1.
- crc_source=1, target transmits "123456789" via tx_load per byte -> crc_out=0x31C3.
- _cs deasserted after 5 clock bits of 0xF0, then a full byte 0x81 -> no rx_valid for the partial byte, rx_data=0x81, miso_oe=0 while deselected.
- _reset asserted mid-byte -> all outputs at reset values immediately. After release, a full 0x55 transfer receives correctly and transmits 0xFF.
